// File: rtl/countdown_timer_if.sv
// countdown_timer_if
//   Groups the countdown timer's control and status signals.
//   Signals:
//     load    - capture cnt_in and start a countdown
//     enab    - count enable; low pauses the count
//     cnt_in  - start value (WIDTH bits)
//     cnt_out - current count (registered)
//     busy    - high while the timer is running (registered)
//     done    - one-cycle completion pulse (registered)
//   Modports:
//     master - the controlling side; drives load/enab/cnt_in
//     slave  - the timer; drives cnt_out/busy/done
interface countdown_timer_if #(
   parameter int WIDTH = 5
);
   logic             load;
   logic             enab;
   logic [WIDTH-1:0] cnt_in;
   logic [WIDTH-1:0] cnt_out;
   logic             busy;
   logic             done;

   modport master (
      output load, enab, cnt_in,
      input  cnt_out, busy, done
   );

   modport slave (
      input  load, enab, cnt_in,
      output cnt_out, busy, done
   );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer
//   Loadable down-counter with an IDLE/RUN state machine and a one-cycle
//   terminal-count pulse. A load of N (N != 0) starts a countdown that
//   reaches zero after N enabled cycles. A load of 0 completes at once.
//   Priority at each edge: rst > load > enab.
//   Ports:
//     clk - rising-edge clock
//     rst - synchronous active-high reset
//     bus - countdown_timer_if.slave (load, enab, cnt_in in;
//           cnt_out, busy, done out, all outputs registered)
//   Optional feature:
//     COUNTDOWN_TIMER_AUTO_RELOAD_EN - when defined, the value captured on
//     each load is reloaded when the count expires, and the timer stays in
//     RUN, producing a periodic done pulse. When undefined, the timer
//     performs a one-shot countdown.
module countdown_timer #(
   parameter int WIDTH = 5
) (
   input  logic               clk,
   input  logic               rst,
   countdown_timer_if.slave   bus
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q,   cnt_d;
   logic             done_q,  done_d;

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload_q, reload_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      reload_d = reload_q;
`endif

      if (bus.load) begin
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
         reload_d = bus.cnt_in;
`endif
         if (bus.cnt_in != '0) begin
            cnt_d   = bus.cnt_in;
            state_d = RUN;
         end else begin
            // Zero-length countdown finishes immediately.
            cnt_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
         end
      end else if (state_q == RUN && bus.enab) begin
         // In RUN the count is never zero, so stopping at one keeps the
         // counter from ever underflowing.
         if (cnt_q > ONE) begin
            cnt_d = cnt_q - ONE;
         end else begin
            done_d = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
            cnt_d   = reload_q;
            state_d = RUN;
`else
            cnt_d   = '0;
            state_d = IDLE;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         reload_q <= '0;
      end else begin
         reload_q <= reload_d;
      end
   end
`endif

   assign bus.cnt_out = cnt_q;
   assign bus.busy    = (state_q == RUN);
   assign bus.done    = done_q;

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter with a run/idle state machine and a single-cycle terminal-count pulse. It is the consuming end of the up-counter path: it takes a value on `cnt_in`, counts it down to zero under `enab`, and signals completion so control logic can sequence off it. It shares the up-counter's `WIDTH` and `load`/`enab` conventions, so the two blocks can be wired back to back.

## Interface
- `WIDTH`, default 5: counter width in bits; legal range 2–32.

- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `load`  input  1: capture `cnt_in` and start a countdown.
- `enab`  input  1: count enable; when low, the counter pauses and holds its value.
- `cnt_in`  input  WIDTH: start value.
- `cnt_out`  output  WIDTH: current count (registered).
- `busy`  output  1: high while state is RUN (registered).
- `done`  output  1: one-cycle pulse when the count reaches zero (registered).

## Operation
- States: IDLE and RUN. `busy` equals (state == RUN).
- Reset state:
  - IDLE.
  - `cnt_out` = 0, `busy` = 0, `done` = 0.
  - Reload register = 0 when `AUTO_RELOAD_EN` is defined.
- Priority at each edge: `rst` > `load` > `enab`.
- `load`, any state:
  - `cnt_in` != 0: `cnt_out` <= `cnt_in`, state <= RUN, `done` <= 0.
  - `cnt_in` == 0: `cnt_out` <= 0, state <= IDLE, `done` <= 1. A zero-length countdown completes immediately.
  - `load` during RUN aborts the current countdown and restarts it. No `done` pulse is issued for the aborted count.
- RUN, `enab` = 1, no `load`:
  - `cnt_out` > 1: `cnt_out` <= `cnt_out` − 1.
  - `cnt_out` == 1: `cnt_out` <= 0, `done` <= 1, state <= IDLE. With `AUTO_RELOAD_EN` defined, behaviour differs; see Configuration.
- RUN, `enab` = 0: all state holds, `done` <= 0.
- IDLE, no `load`:
  - `cnt_out` holds. It never wraps: 0 stays 0 regardless of `enab`.
  - `done` <= 0.
- `done` is high for exactly one cycle per completed countdown and is never held.
- Arithmetic: modulo 2^WIDTH, but the zero guard means underflow never occurs.
- Reset mid-countdown: next edge gives IDLE, `cnt_out` = 0, and no `done` pulse.

## Timing
- `load` sampled at edge k with `cnt_in` = N, N ≥ 1:
  - After edge k: `cnt_out` = N, `busy` = 1.
- With `enab` held high from edge k+1:
  - After edge k+j: `cnt_out` = N − j, for j < N.
  - After edge k+N: `cnt_out` = 0, `done` = 1, `busy` = 0.
  - After edge k+N+1: `done` = 0.
- Latency from `load` to `done` = N enabled cycles. Each low-`enab` cycle in RUN adds one cycle.
- `load` with `cnt_in` = 0 at edge k: `done` = 1 after edge k.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro `COUNTDOWN_TIMER_AUTO_RELOAD_EN`.
- Defined:
  - A WIDTH-bit reload register captures `cnt_in` on every `load`.
  - In RUN, `enab` = 1, `cnt_out` == 1: `cnt_out` <= reload value, `done` <= 1, state stays RUN. This gives a periodic pulse every N enabled cycles.
  - `load` with `cnt_in` = 0 still goes to IDLE with a `done` pulse.
  - The reload register is cleared by `rst`.
- Not defined:
  - No reload register.
  - The block performs a one-shot countdown as described under Operation.

## Test plan
- Reset, then `load` with `cnt_in` = 5, `enab` held high:
  - `cnt_out` sequence 5,4,3,2,1,0.
  - `done` = 1 only in the cycle `cnt_out` = 0.
  - `busy` falls in that same cycle.
- `load` 4, then `enab` low for 3 cycles after the second decrement:
  - `cnt_out` holds at 2 for 3 cycles.
  - `done` arrives 7 cycles after `load`.
- `load` 6, then after 2 decrements `load` 3:
  - `cnt_out` jumps to 3.
  - No `done` pulse until the count reaches 0 from 3.
- `load` 0:
  - `done` = 1 for one cycle, `busy` = 0, `cnt_out` = 0.
  - Then `enab` high for 4 cycles: `cnt_out` stays 0, with no wrap to 31.
- `rst` asserted while `cnt_out` = 3 in RUN:
  - Next cycle: `cnt_out` = 0, `busy` = 0, `done` = 0.
  - `done` never pulses.
- With `COUNTDOWN_TIMER_AUTO_RELOAD_EN` defined, `load` 3 with `enab` high:
  - `cnt_out` sequence 3,2,1,3,2,1,3…
  - `done` pulses every 3 cycles, coinciding with the reload.
  - `busy` stays 1.
